// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared constants and helpers for the fetch sequencer and its redirect arbiter.
// State encodings are kept as plain constants so existing waveform decoders still work.
package fetch_seq_ctrl_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_KILL = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam logic [63:0] RESET_ADDR_DEFAULT = 64'h8000_0000;

    // An instruction is compressed unless its two low opcode bits are both set.
    function automatic logic is_rvc(input logic [1:0] opc);
        return opc != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Icache request/response port: a valid/ready request channel and a one-cycle response strobe.
interface fetch_seq_ctrl_if #(
    parameter int unsigned XLEN = 64
);

    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            resp_valid;
    logic [31:0]     resp_inst;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_inst
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_inst
    );

endinterface

// File: rtl/fetch_seq_ctrl_redirect_arb.sv
// Redirect arbiter: same-cycle priority select (clint > branch > bpu) and the pending
// redirect register, where a pending trap target is never replaced by branch/bpu.
module fetch_seq_ctrl_redirect_arb
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clint_valid,
    input  logic [XLEN-1:0] clint_pc,
    input  logic            branch_valid,
    input  logic [XLEN-1:0] branch_pc,
    input  logic            bpu_valid,
    input  logic [XLEN-1:0] bpu_pc,
    input  logic            pend_clr,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    output logic            redir_wins,
    output logic            pend_valid,
    output logic [XLEN-1:0] pend_pc
);

    logic pend_clint;

    always_comb begin
        redir_valid = clint_valid | branch_valid | bpu_valid;
        if (clint_valid) begin
            redir_pc = clint_pc;
        end else if (branch_valid) begin
            redir_pc = branch_pc;
        end else begin
            redir_pc = bpu_pc;
        end
        // redir_wins says whether this cycle's redirect supersedes the pending one.
        redir_wins = redir_valid & ~(pend_valid & pend_clint & ~clint_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            pend_clint <= 1'b0;
        end else if (pend_clr) begin
            pend_valid <= 1'b0;
            pend_clint <= 1'b0;
        end else if (redir_wins) begin
            pend_valid <= 1'b1;
            pend_pc    <= redir_pc;
            pend_clint <= clint_valid;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, keeps one icache request outstanding, discards stale
// responses after a redirect and buffers one instruction for the IF stage.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter int unsigned        XLEN       = 64,
    parameter logic [XLEN-1:0]    RESET_ADDR = XLEN'(RESET_ADDR_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [XLEN-1:0]        clint_pc_i,
    input  logic                   clint_valid_i,
    input  logic [XLEN-1:0]        branch_pc_i,
    input  logic                   branch_valid_i,
    input  logic [XLEN-1:0]        bpu_pc_i,
    input  logic                   bpu_valid_i,
    fetch_seq_ctrl_if.master       icache,
    input  logic                   ifu_stall_i,
    output logic                   inst_valid_o,
    output logic [31:0]            inst_o,
    output logic [XLEN-1:0]        inst_pc_o,
    output logic                   is_compressed_o,
    output logic                   busy_o
);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_nxt;

    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_wins;
    logic            pend_valid;
    logic [XLEN-1:0] pend_pc;
    logic            pend_clr;

    logic            tgt_valid;
    logic [XLEN-1:0] tgt_pc;
    logic            load_inst;
    logic            drop_inst;

    fetch_seq_ctrl_redirect_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .clint_valid  (clint_valid_i),
        .clint_pc     (clint_pc_i),
        .branch_valid (branch_valid_i),
        .branch_pc    (branch_pc_i),
        .bpu_valid    (bpu_valid_i),
        .bpu_pc       (bpu_pc_i),
        .pend_clr     (pend_clr),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .redir_wins   (redir_wins),
        .pend_valid   (pend_valid),
        .pend_pc      (pend_pc)
    );

    // Target to apply now: the pending redirect merged with whatever arrives this cycle.
    assign tgt_valid = redir_valid | pend_valid;
    assign tgt_pc    = redir_wins ? redir_pc : pend_pc;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pend_clr     = 1'b0;
        load_inst    = 1'b0;
        drop_inst    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
                if (tgt_valid) begin
                    fetch_pc_nxt = tgt_pc;
                    pend_clr     = 1'b1;
                end
            end
            ST_REQ: begin
                // Address is frozen here; redirects only accumulate in the pending register.
                if (icache.req_ready) begin
                    state_nxt = tgt_valid ? ST_KILL : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (icache.resp_valid) begin
                    if (tgt_valid) begin
                        fetch_pc_nxt = tgt_pc;
                        pend_clr     = 1'b1;
                        state_nxt    = ST_REQ;
                    end else begin
                        load_inst    = 1'b1;
                        fetch_pc_nxt = fetch_pc +
                                       (is_rvc(icache.resp_inst[1:0]) ? XLEN'(2) : XLEN'(4));
                        state_nxt    = ST_HOLD;
                    end
                end else if (tgt_valid) begin
                    state_nxt = ST_KILL;
                end
            end
            ST_KILL: begin
                if (icache.resp_valid) begin
                    fetch_pc_nxt = tgt_pc;
                    pend_clr     = 1'b1;
                    state_nxt    = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    fetch_pc_nxt = tgt_pc;
                    pend_clr     = 1'b1;
                    drop_inst    = 1'b1;
                    state_nxt    = ST_REQ;
                end else if (!ifu_stall_i) begin
                    drop_inst = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            fetch_pc        <= RESET_ADDR;
            inst_valid_o    <= 1'b0;
            inst_o          <= '0;
            inst_pc_o       <= '0;
            is_compressed_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (load_inst) begin
                inst_valid_o    <= 1'b1;
                inst_o          <= icache.resp_inst;
                inst_pc_o       <= fetch_pc;
                is_compressed_o <= is_rvc(icache.resp_inst[1:0]);
            end else if (drop_inst) begin
                inst_valid_o <= 1'b0;
            end
        end
    end

    assign icache.req_valid = (state == ST_REQ);
    assign icache.req_addr  = fetch_pc;
    assign busy_o           = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_KILL);

endmodule
